// File: rtl/bsg_ring_echo_node.sv
// Ring echo node: queues inbound packets and answers ECHO/READ, counts ACC.
// Ports: clk_i, reset_n_i, en_i, v_i/data_i/ready_o in, v_o/data_o/yumi_i out.
module bsg_ring_echo_node #(
  parameter int ring_width_p = 80,
  parameter int client_id_p  = 0,
  parameter int fifo_els_p   = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i
);

  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int pl_w  = ring_width_p - 8;

  localparam logic [0:0] idle_s = 1'b0;
  localparam logic [0:0] send_s = 1'b1;

  localparam logic [7:0] id_c = 8'(client_id_p);
  localparam logic [ptr_w:0] full_c = (ptr_w+1)'(fifo_els_p);

  logic [ring_width_p-1:0] mem [fifo_els_p];
  logic [ptr_w-1:0]        rd_ptr;
  logic [ptr_w-1:0]        wr_ptr;
  logic [ptr_w:0]          count;

  logic [0:0]  state;
  logic        live;
  logic [31:0] acc;
  logic [15:0] cnt;
  logic [15:0] err;

  logic full;
  logic empty;
  logic push;
  logic pop;

  logic [ring_width_p-1:0] head;
  logic [7:0]              op;
  logic [pl_w-1:0]         pl;
  logic [pl_w-1:0]         rd_pl;
  logic                    is_echo;
  logic                    is_acc;
  logic                    is_read;

  assign full  = (count == full_c);
  assign empty = (count == '0);

  // live holds ready low until the first edge after reset release
  assign ready_o = en_i & live & ~full;
  assign push    = v_i & ready_o;
  assign pop     = ~empty & ((state == idle_s) | yumi_i);

  assign head  = mem[rd_ptr];
  assign op    = head[ring_width_p-1 -: 8];
  assign pl    = head[pl_w-1:0];
  assign rd_pl = pl_w'({id_c, cnt, err, acc});

  assign is_echo = (op == 8'h01);
  assign is_acc  = (op == 8'h02);
  assign is_read = (op == 8'h03);

  assign v_o = (state == send_s);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live   <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= idle_s;
      data_o <= '0;
      acc    <= '0;
      cnt    <= '0;
      err    <= '0;
    end else begin
      live <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (pop) begin
        unique case (1'b1)
          is_echo: begin
            data_o <= {8'h81, pl};
            state  <= send_s;
          end
          is_read: begin
            data_o <= {8'h83, rd_pl};
            state  <= send_s;
          end
          is_acc: begin
            acc   <= acc + pl[31:0];
            cnt   <= cnt + 16'd1;
            state <= idle_s;
          end
          default: begin
            if (err != 16'hFFFF) begin
              err <= err + 16'd1;
            end
            state <= idle_s;
          end
        endcase
      end else if (state == send_s && yumi_i) begin
        state <= idle_s;
      end
    end
  end

endmodule
